// File: rtl/v_pkg.sv
// Shared types for the banked vector data-memory controller: FSM states, bank count
// and the word-interleaved bank-select rule.
package v_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    DRAIN,
    DONE,
    HOLD
  } dmem_state_e;

  localparam int NUM_DBANKS = 4;

  // Words are interleaved across banks on the two low address bits.
  function automatic logic [1:0] bank_sel(input logic [1:0] addr_lo);
    return addr_lo;
  endfunction

endpackage

// File: rtl/v_dmem_ctrl_if.sv
// Vector memory port plus the lower-priority scalar port of the data-memory controller.
// master = coprocessor/core side, slave = controller.
interface v_dmem_ctrl_if #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  is_vltype;
  logic                  is_vstype;
  logic [ADDR_BITS-1:0]  data_addr0;
  logic [ADDR_BITS-1:0]  data_addr1;
  logic [ADDR_BITS-1:0]  data_addr2;
  logic [ADDR_BITS-1:0]  data_addr3;
  logic [DATA_WIDTH-1:0] v_store_data_0;
  logic [DATA_WIDTH-1:0] v_store_data_1;
  logic [DATA_WIDTH-1:0] v_store_data_2;
  logic [DATA_WIDTH-1:0] v_store_data_3;
  logic [DATA_WIDTH-1:0] v_load_data_0;
  logic [DATA_WIDTH-1:0] v_load_data_1;
  logic [DATA_WIDTH-1:0] v_load_data_2;
  logic [DATA_WIDTH-1:0] v_load_data_3;
  logic                  v_busy;
  logic                  v_done;
  logic                  s_req;
  logic                  s_we;
  logic [ADDR_BITS-1:0]  s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_gnt;
  logic [DATA_WIDTH-1:0] s_rdata;

  modport master (
    output is_vltype, is_vstype,
    output data_addr0, data_addr1, data_addr2, data_addr3,
    output v_store_data_0, v_store_data_1, v_store_data_2, v_store_data_3,
    input  v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3,
    input  v_busy, v_done,
    output s_req, s_we, s_addr, s_wdata,
    input  s_gnt, s_rdata
  );

  modport slave (
    input  is_vltype, is_vstype,
    input  data_addr0, data_addr1, data_addr2, data_addr3,
    input  v_store_data_0, v_store_data_1, v_store_data_2, v_store_data_3,
    output v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3,
    output v_busy, v_done,
    input  s_req, s_we, s_addr, s_wdata,
    output s_gnt, s_rdata
  );

endinterface

// File: rtl/v_dmem_bank.sv
// Single-port synchronous RAM bank, read-first; rdata valid 1 cycle after the access.
// No backpressure: one access per cycle, contents are never reset.
module v_dmem_bank #(
  parameter int ROW_BITS   = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ROW_BITS-1:0]   addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ROW_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/v_dmem_ctrl.sv
// Four-bank vector data-memory controller; conflict-free vector op completes (v_done) 3 cycles after request.
// Bank conflicts serialise one lane per bank per cycle; scalar port is granted only in IDLE/HOLD.
module v_dmem_ctrl
  import v_pkg::*;
#(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  v_dmem_ctrl_if.slave bus
);

  localparam int ROW_BITS = ADDR_BITS - 2;

  dmem_state_e           state;
  logic [3:0]            pending;
  logic [3:0]            lane_gnt;
  logic [3:0]            cap_q;
  logic                  op_load;
  logic [ADDR_BITS-1:0]  addr_q  [4];
  logic [DATA_WIDTH-1:0] wdata_q [4];
  logic [DATA_WIDTH-1:0] ld_q    [4];
  logic [ADDR_BITS-1:0]  addr_in [4];
  logic [DATA_WIDTH-1:0] wdata_in[4];
  logic                  v_busy_q;
  logic                  v_done_q;
  logic                  vreq;
  logic                  s_gnt;
  logic                  s_rd_q;
  logic [1:0]            s_bank_q;
  logic [DATA_WIDTH-1:0] s_hold_q;
  logic [NUM_DBANKS-1:0] bank_taken;

  logic                  b_we   [NUM_DBANKS];
  logic [ROW_BITS-1:0]   b_addr [NUM_DBANKS];
  logic [DATA_WIDTH-1:0] b_wdata[NUM_DBANKS];
  logic [DATA_WIDTH-1:0] b_rdata[NUM_DBANKS];

  assign addr_in[0]  = bus.data_addr0;
  assign addr_in[1]  = bus.data_addr1;
  assign addr_in[2]  = bus.data_addr2;
  assign addr_in[3]  = bus.data_addr3;
  assign wdata_in[0] = bus.v_store_data_0;
  assign wdata_in[1] = bus.v_store_data_1;
  assign wdata_in[2] = bus.v_store_data_2;
  assign wdata_in[3] = bus.v_store_data_3;

  assign vreq  = bus.is_vltype | bus.is_vstype;
  // A new vector request in IDLE wins over the scalar port; in HOLD the held request is already served.
  assign s_gnt = bus.s_req & (((state == IDLE) & ~vreq) | (state == HOLD));

  // Lowest-index pending lane wins each bank.
  always_comb begin
    lane_gnt   = '0;
    bank_taken = '0;
    if (state == SERVE) begin
      for (int l = 0; l < 4; l++) begin
        if (pending[l] && !bank_taken[bank_sel(addr_q[l][1:0])]) begin
          lane_gnt[l]                           = 1'b1;
          bank_taken[bank_sel(addr_q[l][1:0])] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_DBANKS; b++) begin
      b_we[b]    = s_gnt & bus.s_we & (bank_sel(bus.s_addr[1:0]) == 2'(b));
      b_addr[b]  = bus.s_addr[ADDR_BITS-1:2];
      b_wdata[b] = bus.s_wdata;
      for (int l = 0; l < 4; l++) begin
        if (lane_gnt[l] && (bank_sel(addr_q[l][1:0]) == 2'(b))) begin
          b_we[b]    = ~op_load;
          b_addr[b]  = addr_q[l][ADDR_BITS-1:2];
          b_wdata[b] = wdata_q[l];
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_DBANKS; b++) begin : g_bank
    v_dmem_bank #(
      .ROW_BITS  (ROW_BITS),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk  (clk),
      .we   (b_we[b]),
      .addr (b_addr[b]),
      .wdata(b_wdata[b]),
      .rdata(b_rdata[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      op_load  <= 1'b0;
      cap_q    <= '0;
      v_busy_q <= 1'b0;
      v_done_q <= 1'b0;
      s_rd_q   <= 1'b0;
      s_bank_q <= '0;
      s_hold_q <= '0;
      for (int l = 0; l < 4; l++) begin
        addr_q[l]  <= '0;
        wdata_q[l] <= '0;
        ld_q[l]    <= '0;
      end
    end else begin
      // Bank data from last cycle's load grants lands in the granted lanes.
      cap_q <= op_load ? lane_gnt : 4'b0000;
      for (int l = 0; l < 4; l++) begin
        if (cap_q[l]) begin
          ld_q[l] <= b_rdata[bank_sel(addr_q[l][1:0])];
        end
      end
      s_rd_q <= s_gnt & ~bus.s_we;
      if (s_gnt) begin
        s_bank_q <= bank_sel(bus.s_addr[1:0]);
      end
      if (s_rd_q) begin
        s_hold_q <= b_rdata[s_bank_q];
      end
      v_busy_q <= 1'b0;
      v_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (vreq) begin
            for (int l = 0; l < 4; l++) begin
              addr_q[l]  <= addr_in[l];
              wdata_q[l] <= wdata_in[l];
            end
            op_load  <= bus.is_vltype;
            pending  <= 4'b1111;
            v_busy_q <= 1'b1;
            state    <= SERVE;
          end
        end
        SERVE: begin
          pending  <= pending & ~lane_gnt;
          v_busy_q <= 1'b1;
          if ((pending & ~lane_gnt) == 4'b0000) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          v_done_q <= 1'b1;
          state    <= DONE;
        end
        DONE: state <= HOLD;
        HOLD: begin
          if (!vreq) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.v_load_data_0 = ld_q[0];
  assign bus.v_load_data_1 = ld_q[1];
  assign bus.v_load_data_2 = ld_q[2];
  assign bus.v_load_data_3 = ld_q[3];
  assign bus.v_busy        = v_busy_q;
  assign bus.v_done        = v_done_q;
  assign bus.s_gnt         = s_gnt;
  assign bus.s_rdata       = s_rd_q ? b_rdata[s_bank_q] : s_hold_q;

endmodule

// File: tb/tb_v_dmem_ctrl.sv
// Bench for v_dmem_ctrl: directed scenarios plus randomized vector/scalar traffic
// checked against a flat word-array memory model and a round-count latency rule.
module tb_v_dmem_ctrl;

  localparam int AB = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  v_dmem_ctrl_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) bus ();

  v_dmem_ctrl #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] vld[4];
  assign vld[0] = bus.v_load_data_0;
  assign vld[1] = bus.v_load_data_1;
  assign vld[2] = bus.v_load_data_2;
  assign vld[3] = bus.v_load_data_3;

  logic [DW-1:0] mem[2**AB];
  logic [DW-1:0] ld_model[4];
  logic [AB-1:0] va[4];
  logic [DW-1:0] vd[4];
  int n_chk  = 0;
  int n_pass = 0;
  int gnt_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AB-1:0] rnd_addr();
    return AB'($urandom_range(0, 2**AB - 1));
  endfunction

  task automatic s_write(input logic [AB-1:0] a, input logic [DW-1:0] d);
    bus.s_req = 1'b1; bus.s_we = 1'b1; bus.s_addr = a; bus.s_wdata = d;
    @(negedge clk);
    if (bus.s_gnt !== 1'b1) gnt_err++;
    tick();
    bus.s_req = 1'b0; bus.s_we = 1'b0;
    mem[a] = d;
  endtask

  task automatic s_read(input string tag, input logic [AB-1:0] a);
    bus.s_req = 1'b1; bus.s_we = 1'b0; bus.s_addr = a;
    @(negedge clk);
    check({tag, "_gnt"}, bus.s_gnt, 1);
    tick();
    bus.s_req = 1'b0;
    @(negedge clk);
    check({tag, "_rdata"}, bus.s_rdata, mem[a]);
    tick();
  endtask

  // Issue one vector op from IDLE and follow it for its whole lifetime.
  task automatic vec_op(input string tag, input bit ld, input bit both, input int hold, input bit sreq_on);
    int cnt[4];
    int rounds, exp_done, hold_len, busy_err, sg_err, done_cnt, done_at;
    cnt = '{0, 0, 0, 0};
    rounds = 0;
    for (int l = 0; l < 4; l++) cnt[va[l][1:0]]++;
    for (int b = 0; b < 4; b++) if (cnt[b] > rounds) rounds = cnt[b];
    exp_done = 2 + rounds;
    if (ld) for (int l = 0; l < 4; l++) ld_model[l] = mem[va[l]];
    else    for (int l = 0; l < 4; l++) mem[va[l]] = vd[l];
    hold_len = (hold > exp_done + 1) ? hold : exp_done + 1;

    bus.is_vltype = ld;
    bus.is_vstype = !ld || both;
    bus.data_addr0 = va[0]; bus.data_addr1 = va[1];
    bus.data_addr2 = va[2]; bus.data_addr3 = va[3];
    bus.v_store_data_0 = vd[0]; bus.v_store_data_1 = vd[1];
    bus.v_store_data_2 = vd[2]; bus.v_store_data_3 = vd[3];
    bus.s_req = sreq_on; bus.s_we = 1'b0; bus.s_addr = rnd_addr();
    busy_err = 0; sg_err = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k <= hold_len + 1; k++) begin
      @(negedge clk);
      if (bus.v_busy !== ((k >= 1) && (k < exp_done))) busy_err++;
      if (bus.v_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (bus.s_gnt !== (sreq_on && (k > exp_done))) sg_err++;
      tick();
      if (k == hold_len - 1) begin
        bus.is_vltype = 1'b0;
        bus.is_vstype = 1'b0;
      end
    end
    bus.s_req = 1'b0;
    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_err"}, busy_err, 0);
    if (sreq_on) check({tag, "_sgnt_err"}, sg_err, 0);
    for (int l = 0; l < 4; l++) check($sformatf("%s_ld%0d", tag, l), vld[l], ld_model[l]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int errs;
    logic [DW-1:0] held;
    bus.is_vltype = 0; bus.is_vstype = 0;
    bus.data_addr0 = 0; bus.data_addr1 = 0; bus.data_addr2 = 0; bus.data_addr3 = 0;
    bus.v_store_data_0 = 0; bus.v_store_data_1 = 0; bus.v_store_data_2 = 0; bus.v_store_data_3 = 0;
    bus.s_req = 0; bus.s_we = 0; bus.s_addr = 0; bus.s_wdata = 0;
    for (int l = 0; l < 4; l++) ld_model[l] = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", bus.v_busy, 0);
    check("rst_done", bus.v_done, 0);
    check("rst_sgnt", bus.s_gnt, 0);
    check("rst_srdata", bus.s_rdata, 0);
    for (int l = 0; l < 4; l++) check($sformatf("rst_ld%0d", l), vld[l], 0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < 2**AB; a++) s_write(AB'(a), $urandom);
    check("preload_gnt_err", gnt_err, 0);

    s_write(0, 32'h11); s_write(1, 32'h22); s_write(2, 32'h33); s_write(3, 32'h44);
    va = '{11'd0, 11'd1, 11'd2, 11'd3};
    vec_op("ld0123", 1, 0, 0, 0);

    va = '{11'd4, 11'd8, 11'd12, 11'd16};
    vd = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    vec_op("st_bank0", 0, 0, 0, 0);
    vec_op("ld_bank0", 1, 0, 0, 0);

    va = '{11'd5, 11'd5, 11'd5, 11'd5};
    vd = '{32'd1, 32'd2, 32'd3, 32'd4};
    vec_op("st_dup5", 0, 0, 0, 0);
    s_read("rd5", 5);
    held = mem[5];
    s_write(100, 32'hDEAD_BEEF);
    @(negedge clk);
    check("srdata_hold", bus.s_rdata, held);
    tick();
    vec_op("ld_dup5", 1, 0, 0, 0);

    va = '{11'd7, 11'd9, 11'd10, 11'd200};
    vec_op("ld_sreq", 1, 0, 0, 1);
    vec_op("ld_hold10", 1, 0, 10, 0);
    vec_op("ld_both", 1, 1, 0, 0);

    // Reset during SERVE of a 4-way conflicting store: only lane 0 has been written.
    va = '{11'd4, 11'd8, 11'd12, 11'd16};
    vd = '{32'h5555_0000, 32'h5555_1111, 32'h5555_2222, 32'h5555_3333};
    bus.is_vstype = 1'b1;
    bus.data_addr0 = va[0]; bus.data_addr1 = va[1]; bus.data_addr2 = va[2]; bus.data_addr3 = va[3];
    bus.v_store_data_0 = vd[0]; bus.v_store_data_1 = vd[1];
    bus.v_store_data_2 = vd[2]; bus.v_store_data_3 = vd[3];
    tick();
    tick();
    rst = 1'b1;
    bus.is_vstype = 1'b0;
    #1;
    check("midrst_busy", bus.v_busy, 0);
    tick();
    rst = 1'b0;
    mem[4] = vd[0];
    for (int l = 0; l < 4; l++) ld_model[l] = '0;
    errs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.v_done !== 1'b0 || bus.v_busy !== 1'b0) errs++;
      tick();
    end
    check("midrst_quiet", errs, 0);
    s_read("midrst_rd4", 4);
    s_read("midrst_rd8", 8);
    s_read("midrst_rd12", 12);

    for (int i = 0; i < 60; i++) begin
      int mode;
      logic [AB-1:0] base;
      logic [1:0] b;
      bit ld;
      mode = $urandom_range(0, 2);
      b    = 2'($urandom_range(0, 3));
      base = rnd_addr();
      for (int l = 0; l < 4; l++) begin
        case (mode)
          0:       va[l] = rnd_addr();
          1:       va[l] = {9'($urandom_range(0, 511)), b};
          default: va[l] = ($urandom_range(0, 1) == 1) ? base : rnd_addr();
        endcase
        vd[l] = $urandom;
      end
      ld = ($urandom_range(0, 1) == 1);
      vec_op($sformatf("rnd%0d", i), ld, ld && ($urandom_range(0, 3) == 0),
             $urandom_range(0, 8), ($urandom_range(0, 1) == 1));
      if (i % 4 == 0) s_read($sformatf("rnd%0d_srd", i), va[$urandom_range(0, 3)]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/v_dmem_ctrl.md
Name: v_dmem_ctrl

Overview:
Banked vector data-memory controller that answers the coprocessor's vector memory port: is_vltype/is_vstype, data_addr0..3, v_store_data_0..3 and v_load_data_0..3.
- Holds four word-interleaved single-port banks.
- Serialises bank conflicts among the four lane addresses.
- Returns per-lane load data.
- Serves a lower-priority scalar-core port while the vector side is idle.

Parameters:
ADDR_BITS, 11, word-address width; total depth 2**ADDR_BITS words, each bank 2**(ADDR_BITS-2)
DATA_WIDTH, 32, word width (matches DATAMEM_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
is_vltype  in  1  vector load request (level, held by coprocessor)
is_vstype  in  1  vector store request (level)
data_addr0..3  in  ADDR_BITS each  per-lane word addresses
v_store_data_0..3  in  DATA_WIDTH each  per-lane store data
v_load_data_0..3  out  DATA_WIDTH each  per-lane load data, registered
v_busy  out  1  vector transaction in progress
v_done  out  1  one-cycle completion pulse
s_req  in  1  scalar access request
s_we  in  1  scalar write enable
s_addr  in  ADDR_BITS  scalar word address
s_wdata  in  DATA_WIDTH  scalar write data
s_gnt  out  1  scalar request accepted this cycle
s_rdata  out  DATA_WIDTH  scalar read data, valid the cycle after s_gnt

Behaviour:
Reset values:
- All outputs are 0; state is IDLE; pending mask is 0.
- Bank contents are not reset.
- rst mid-transaction aborts immediately to IDLE. Writes already performed remain; no v_done is produced.

Bank mapping:
- bank = addr[1:0]; row = addr[ADDR_BITS-1:2].
- Each bank is synchronous: read data appears 1 cycle after the access.

States:
- IDLE. If is_vltype|is_vstype, latch the 4 addresses, the 4 store data words and op (load if is_vltype, else store), set pending=4'b1111 and go to SERVE. s_req is not granted in this cycle.
  - Both request bits high: treated as a load.
  - Otherwise, if s_req: s_gnt=1 and the bank access is performed this cycle. On a read, s_rdata is updated next cycle and held until the next scalar read.
- SERVE. For each bank, grant the lowest-index pending lane mapped to it; perform the read or write and clear that lane's pending bit. Up to 4 lanes complete per cycle. When pending reaches 0 after this cycle's grants, go to DRAIN.
- DRAIN. Bank read data from the last SERVE cycle is captured into the granted lanes' v_load_data registers (capture also occurs each SERVE cycle for the previous cycle's grants). Go to DONE.
- DONE. v_done=1 for exactly this cycle; go to HOLD.
- HOLD. Wait until is_vltype=0 and is_vstype=0, then go to IDLE. This prevents re-issuing the same held instruction. s_req is serviced in HOLD exactly as in IDLE.

Outputs and timing:
- v_busy=1 in SERVE and DRAIN only.
- Latency, request seen in IDLE at cycle 0: conflict-free is SERVE at 1, DRAIN at 2, v_done at 3. Each extra conflict round adds 1 cycle; all four lanes on one bank gives v_done at 6.
- Stores update v_load_data registers not at all; they keep their previous values.

Duplicate addresses:
- Same-address lanes serialise by index. For stores, the highest-index lane's data is final.
- Two loads from the same address return identical data.

Out-of-range addresses are impossible by width.

Decomposition:
- v_pkg:
  - dmem_state_e (IDLE, SERVE, DRAIN, DONE, HOLD)
  - localparam NUM_DBANKS = 4
  - a bank-select helper function
- One sub-module: v_dmem_bank, a single-port synchronous RAM with we, addr, wdata and rdata, 1-cycle read. It is instantiated 4 times. The per-bank grant and mux logic stays in v_dmem_ctrl.

Test Plan:
- Scalar writes 0x11,0x22,0x33,0x44 to addrs 0..3, then a vector load of addrs 0,1,2,3 at cycle 0 -> v_busy at cycles 1-2, v_done at cycle 3, v_load_data_0..3 = 0x11,0x22,0x33,0x44.
- Vector store of data A0..A3 to addrs 4,8,12,16 (all bank 0) -> v_done at cycle 6; a subsequent vector load of the same addrs returns A0..A3.
- Vector store with all lanes at addr 5, data 1,2,3,4 -> scalar read of 5 returns 4.
- s_req and is_vltype rise in the same IDLE cycle -> s_gnt=0, vector served; s_gnt=1 in the first HOLD cycle while s_req is held.
- is_vltype held high for 10 cycles -> exactly one v_done pulse; the next request is accepted only after is_vltype drops and rises again.
- rst asserted during SERVE of a conflicting store -> next cycle state IDLE, v_busy=0, v_done never pulses; lanes written before reset are visible to scalar reads.
